// File: rtl/conv_pass_scheduler_if.sv
// Handshake bundle shared by conv_pass_scheduler, the convolution engine and the downstream sink.
interface conv_pass_scheduler_if #(
  parameter int unsigned IDX_W = 4
);
  logic             start;
  logic             abort;
  logic             conv_finished;
  logic             out_ready;
  logic             conv_enable;
  logic             conv_reply;
  logic [IDX_W-1:0] kernel_sel;
  logic             out_valid;
  logic [IDX_W-1:0] out_pass_idx;
  logic             busy;
  logic             layer_done;
  logic             error;

  modport slave (
    input  start, abort, conv_finished, out_ready,
    output conv_enable, conv_reply, kernel_sel, out_valid, out_pass_idx, busy, layer_done, error
  );

  modport master (
    output start, abort, conv_finished, out_ready,
    input  conv_enable, conv_reply, kernel_sel, out_valid, out_pass_idx, busy, layer_done, error
  );
endinterface

// File: rtl/conv_pass_scheduler.sv
// Sequences NUM_PASSES kernel-pair passes of a conv engine per layer, with output handshake.
// Optional RUN watchdog enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_pass_scheduler #(
  parameter int unsigned NUM_PASSES     = 2,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                  i_clk,
  input logic                  i_reset,
  conv_pass_scheduler_if.slave bus
);

  if (NUM_PASSES < 1 || NUM_PASSES > 16 || NUM_PASSES > (1 << IDX_W) || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("conv_pass_scheduler: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StHold, StAck, StDone, StErr} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PASSES - 1);

  state_e           r_state_q, w_state_d;
  logic [IDX_W-1:0] r_idx_q, w_idx_d;
  logic             w_timeout;

  logic             w_conv_enable, w_conv_reply, w_out_valid, w_busy, w_layer_done, w_error;
  logic [IDX_W-1:0] w_kernel_sel, w_out_pass_idx;
  logic             r_conv_enable, r_conv_reply, r_out_valid, r_busy, r_layer_done;
  logic [IDX_W-1:0] r_kernel_sel, r_out_pass_idx;

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_cnt_q, w_cnt_d;
  logic            r_error;

  assign w_timeout = (32'(r_cnt_q) == TIMEOUT_CYCLES - 1);

  // Counter only survives consecutive RUN cycles, so it is zero on every RUN entry.
  always_comb begin
    w_cnt_d = '0;
    if (r_state_q == StRun && w_state_d == StRun) w_cnt_d = r_cnt_q + CntW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt_q <= '0;
      r_error <= 1'b0;
    end else begin
      r_cnt_q <= w_cnt_d;
      r_error <= w_error;
    end
  end

  assign bus.error = r_error;
`else
  assign w_timeout = 1'b0;
  assign bus.error = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state_q;
    w_idx_d   = r_idx_q;
    if (bus.abort) begin
      w_state_d = StIdle;
      w_idx_d   = '0;
    end else begin
      case (r_state_q)
        StIdle, StErr: begin
          if (bus.start) begin
            w_state_d = StLoad;
            w_idx_d   = '0;
          end
        end
        StLoad: w_state_d = StRun;
        StRun: begin
          if (bus.conv_finished) w_state_d = StHold;
          else if (w_timeout)    w_state_d = StErr;
        end
        StHold: begin
          if (bus.out_ready) w_state_d = StAck;
        end
        StAck: begin
          if (r_idx_q == LastIdx) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StLoad;
            w_idx_d   = r_idx_q + IDX_W'(1);
          end
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end

    // Outputs decoded from the next state, then registered below.
    w_conv_enable  = (w_state_d == StRun);
    w_conv_reply   = (w_state_d == StAck);
    w_out_valid    = (w_state_d == StHold);
    w_layer_done   = (w_state_d == StDone);
    w_error        = (w_state_d == StErr);
    w_busy         = (w_state_d != StIdle) && (w_state_d != StErr);
    w_kernel_sel   = '0;
    w_out_pass_idx = '0;
    if (w_state_d inside {StLoad, StRun, StHold, StAck}) w_kernel_sel = w_idx_d;
    if (w_state_d == StHold) w_out_pass_idx = w_idx_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state_q      <= StIdle;
      r_idx_q        <= '0;
      r_conv_enable  <= 1'b0;
      r_conv_reply   <= 1'b0;
      r_kernel_sel   <= '0;
      r_out_valid    <= 1'b0;
      r_out_pass_idx <= '0;
      r_busy         <= 1'b0;
      r_layer_done   <= 1'b0;
    end else begin
      r_state_q      <= w_state_d;
      r_idx_q        <= w_idx_d;
      r_conv_enable  <= w_conv_enable;
      r_conv_reply   <= w_conv_reply;
      r_kernel_sel   <= w_kernel_sel;
      r_out_valid    <= w_out_valid;
      r_out_pass_idx <= w_out_pass_idx;
      r_busy         <= w_busy;
      r_layer_done   <= w_layer_done;
    end
  end

`ifndef CONV_SCHED_TIMEOUT_EN
  logic w_unused;
  assign w_unused = w_error;
`endif

  assign bus.conv_enable  = r_conv_enable;
  assign bus.conv_reply   = r_conv_reply;
  assign bus.kernel_sel   = r_kernel_sel;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pass_idx = r_out_pass_idx;
  assign bus.busy         = r_busy;
  assign bus.layer_done   = r_layer_done;

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Scoreboard bench for conv_pass_scheduler: random engine/sink behaviour against a pass-list model.
module tb_conv_pass_scheduler;
  localparam int unsigned NP = 2;
  localparam int unsigned IW = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_pass_scheduler_if #(.IDX_W(IW)) bus ();

  conv_pass_scheduler #(
    .NUM_PASSES    (NP),
    .IDX_W         (IW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_kern_q[$];
  int exp_out_q[$];
  int exp_done_q[$];
  int eng_mode = 1;   // 0 random delay, >0 fixed delay, <0 never finishes
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  bit noise_en = 1'b0;
  bit mon_en   = 1'b0;

  function automatic void chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // A full layer yields every pass index once, in order, then one layer_done.
  function automatic void push_layer();
    for (int p = 0; p < int'(NP); p++) begin
      exp_kern_q.push_back(p);
      exp_out_q.push_back(p);
    end
    exp_done_q.push_back(1);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input bit glitch, input string tag);
    for (int k = 0; k < 400; k++) begin
      if (!bus.busy) break;
      bus.start = glitch && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_conv_enable"}, bus.conv_enable, 0);
    chk({tag, "_conv_reply"}, bus.conv_reply, 0);
    chk({tag, "_kernel_sel"}, bus.kernel_sel, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_pass_idx"}, bus.out_pass_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_layer_done"}, bus.layer_done, 0);
    chk({tag, "_error"}, bus.error, 0);
  endtask

  // Engine: raises conv_finished a chosen number of cycles into each RUN.
  initial begin
    int run_cnt;
    int dly;
    run_cnt = 0;
    dly = 1;
    bus.conv_finished = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.conv_enable) begin
        if (run_cnt == 0) dly = (eng_mode == 0) ? int'($urandom_range(1, 6)) : eng_mode;
        run_cnt++;
        bus.conv_finished = (run_cnt == dly);
      end else begin
        run_cnt = 0;
        bus.conv_finished = noise_en && ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Downstream sink.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    bit en_prev;
    bit acc_prev;
    bit hold_pend;
    int hold_idx;
    en_prev = 1'b0;
    acc_prev = 1'b0;
    hold_pend = 1'b0;
    hold_idx = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.conv_enable && !en_prev) begin
          chk("run_expected", int'(exp_kern_q.size() > 0), 1);
          if (exp_kern_q.size() > 0) chk("kernel_sel", bus.kernel_sel, exp_kern_q.pop_front());
        end
        if (hold_pend) begin
          chk("hold_out_valid", bus.out_valid, 1);
          chk("hold_out_pass_idx", bus.out_pass_idx, hold_idx);
        end
        if (acc_prev || bus.conv_reply) chk("conv_reply", bus.conv_reply, acc_prev);
        if (acc_prev) chk("ack_out_valid", bus.out_valid, 0);
        if (bus.layer_done) begin
          chk("layer_done_expected", int'(exp_done_q.size() > 0), 1);
          if (exp_done_q.size() > 0) begin
            void'(exp_done_q.pop_front());
            chk("done_after_all_passes", exp_out_q.size(), 0);
          end
        end
        acc_prev = 1'b0;
        hold_pend = 1'b0;
        if (rst_n && !bus.abort && bus.out_valid) begin
          if (bus.out_ready) begin
            chk("out_expected", int'(exp_out_q.size() > 0), 1);
            if (exp_out_q.size() > 0) chk("out_pass_idx", bus.out_pass_idx, exp_out_q.pop_front());
            acc_prev = 1'b1;
          end else begin
            hold_pend = 1'b1;
            hold_idx = bus.out_pass_idx;
          end
        end
      end
      en_prev = bus.conv_enable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_en;
    int lat_done;
    bit hit;
    int run_cycles;

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Minimum latency, everything immediate.
    eng_mode = 1; rdy_mode = 1;
    push_layer();
    @(posedge clk); #1 bus.start = 1'b1;
    lat_en = -1;
    lat_done = -1;
    for (int n = 1; n <= 60 && lat_done < 0; n++) begin
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      if (bus.conv_enable && lat_en < 0) lat_en = n;
      if (bus.layer_done) lat_done = n;
    end
    chk("start_to_enable", lat_en, 2);
    chk("start_to_layer_done", lat_done, 4 * int'(NP) + 1);
    @(posedge clk); #1;
    wait_idle(1'b0, "latency");

    // Finish 3 cycles into RUN, sink always ready, stray starts while busy.
    eng_mode = 3;
    push_layer();
    pulse_start();
    wait_idle(1'b1, "fixed3");

    // Sink stalls HOLD for 10 cycles.
    eng_mode = 2; rdy_mode = 2;
    push_layer();
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = bus.out_valid;
    end
    chk("stall_reach_hold", hit, 1);
    repeat (10) @(negedge clk);
    rdy_mode = 1;
    @(posedge clk); #2;
    wait_idle(1'b0, "stall");

    // Abort during RUN of pass 1.
    eng_mode = 10;
    exp_kern_q.push_back(0);
    exp_kern_q.push_back(1);
    exp_out_q.push_back(0);
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk); #1;
      hit = bus.conv_enable && (bus.kernel_sel == 1);
    end
    chk("abort_reach_pass1", hit, 1);
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_conv_enable", bus.conv_enable, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_kernel_sel", bus.kernel_sel, 0);
    repeat (5) @(negedge clk);
    eng_mode = 0; rdy_mode = 0;
    push_layer();
    pulse_start();
    wait_idle(1'b1, "after_abort");

    // Reset while stalled in HOLD.
    eng_mode = 1; rdy_mode = 2;
    exp_kern_q.push_back(0);
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = bus.out_valid;
    end
    chk("reset_reach_hold", hit, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("hold_reset");
    rdy_mode = 1;
    @(posedge clk); #1 rst_n = 1'b1;

    // Random layers with spurious conv_finished and stray starts.
    eng_mode = 0; rdy_mode = 0; noise_en = 1'b1;
    for (int l = 0; l < 12; l++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      push_layer();
      pulse_start();
      wait_idle(1'b1, "random");
    end
    noise_en = 1'b0;

`ifdef CONV_SCHED_TIMEOUT_EN
    eng_mode = -1; rdy_mode = 1;
    exp_kern_q.push_back(0);
    pulse_start();
    run_cycles = 0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (bus.conv_enable) run_cycles++;
      hit = bus.error;
    end
    chk("timeout_error", hit, 1);
    chk("timeout_run_cycles", run_cycles, int'(TO));
    chk("timeout_busy", bus.busy, 0);
    chk("timeout_conv_enable", bus.conv_enable, 0);
    eng_mode = 0;
    push_layer();
    pulse_start();
    @(negedge clk);
    chk("err_restart_error", bus.error, 0);
    chk("err_restart_busy", bus.busy, 1);
    chk("err_restart_conv_enable", bus.conv_enable, 0);
    chk("err_restart_kernel_sel", bus.kernel_sel, 0);
    @(posedge clk); #1;
    wait_idle(1'b0, "err_restart");
`else
    run_cycles = 0;
    chk("error_stays_low", bus.error, run_cycles);
`endif

    repeat (4) @(negedge clk);
    chk("kern_q_drained", exp_kern_q.size(), 0);
    chk("out_q_drained", exp_out_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_pass_scheduler.md
CONV_PASS_SCHEDULER -- requirements
Module: conv_pass_scheduler

Interface
REQ-001 SHALL have parameter NUM_PASSES, default 2, number of kernel-pair passes per layer (1..16).
REQ-002 SHALL have parameter IDX_W, default 4, width of pass index.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max RUN-state cycles before error.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin a layer; honoured only in IDLE.
REQ-007 SHALL have port abort  input  1  return to IDLE from any state.
REQ-008 SHALL have port conv_finished  input  1  engine result ready (engine finished_for_next_device).
REQ-009 SHALL have port out_ready  input  1  downstream accepts current feature map.
REQ-010 SHALL have port conv_enable  output  1  engine enable.
REQ-011 SHALL have port conv_reply  output  1  acknowledge to engine (engine reply_from_next_device).
REQ-012 SHALL have port kernel_sel  output  IDX_W  kernel-pair select for current pass.
REQ-013 SHALL have port out_valid  output  1  feature map of pass out_pass_idx available.
REQ-014 SHALL have port out_pass_idx  output  IDX_W  pass index tagged to out_valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE and ERR.
REQ-016 SHALL have port layer_done  output  1  one-cycle pulse after last pass accepted.
REQ-017 SHALL have port error  output  1  sticky watchdog timeout flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, HOLD, ACK, DONE, ERR; all outputs registered.
REQ-019 IDLE: start=1 -> LOAD next cycle, pass index cleared to 0, error cleared.
REQ-020 LOAD: exactly one cycle, kernel_sel=index, conv_enable=0; -> RUN.
REQ-021 RUN: conv_enable=1, kernel_sel held; conv_finished=1 -> HOLD, conv_enable=0 next cycle.
REQ-022 HOLD: out_valid=1, out_pass_idx=index, held stable until out_ready=1 sampled; out_ready=1 -> ACK.
REQ-023 ACK: exactly one cycle, conv_reply=1, out_valid=0; -> DONE if index==NUM_PASSES-1, else LOAD with index+1.
REQ-024 DONE: layer_done=1 one cycle; -> IDLE.
REQ-025 conv_reply SHALL be high only in ACK; conv_finished outside RUN SHALL be ignored.
REQ-026 start outside IDLE and ERR SHALL be ignored; start in ERR -> LOAD, error cleared, index 0.
REQ-027 abort=1 in any state SHALL force IDLE next cycle, all outputs to reset values, no layer_done; abort has priority over start and all transitions.
REQ-028 Minimum pass latency: start to first conv_enable = 2 cycles; single-pass layer with conv_finished and out_ready immediate = layer_done 5 cycles after start.
REQ-029 Index SHALL never exceed NUM_PASSES-1; no wrap-around.

Reset
REQ-030 reset=0 at a rising clk edge SHALL force IDLE, index 0, timeout counter 0, every output 0, including mid-pass.
REQ-031 reset SHALL have priority over abort and start.

Configuration
REQ-032 Macro CONV_SCHED_TIMEOUT_EN defined: counter increments each RUN cycle, cleared on RUN entry; reaching TIMEOUT_CYCLES without conv_finished -> ERR, conv_enable=0, error=1 until start or reset.
REQ-033 Macro undefined: no counter, ERR unreachable, error tied 0, RUN waits indefinitely.

Verification
REQ-034 NUM_PASSES=2, start pulse, conv_finished 3 cycles into each RUN, out_ready held 1 -> kernel_sel 0 then 1, out_pass_idx 0 then 1, two conv_reply pulses, one layer_done.
REQ-035 out_ready=0 for 10 cycles in HOLD -> out_valid and out_pass_idx stable 10 cycles, conv_reply only after out_ready=1.
REQ-036 abort in RUN of pass 1 -> IDLE next cycle, conv_enable=0, no layer_done; subsequent start restarts at kernel_sel=0.
REQ-037 reset=0 during HOLD -> all outputs 0 next edge; start while busy -> no effect.
REQ-038 With CONV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, conv_finished never -> error=1 after 16 RUN cycles, busy=0; start -> error=0, LOAD.
